led_scanner: RTL and testbench

Parametrised, bus-programmable successor to the fixed 5-LED scanner peripheral. Drives a WIDTH-bit LED bank in bounce, wrap, stopped or manual-pattern mode at a software-set step period. Sits on the memory bus as a slave and adds read-back and status. Instantiated per LED bank by the SoC top level.

---
 rtl/led_scanner.sv | 238 +++++++++++++++++++++++
 tb/tb_led_scanner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_scanner.sv
// led_scanner: bus-programmable LED bank scanner.
//
// Drives a WIDTH-bit LED bank in stop, bounce, wrap or manual-pattern mode,
// stepping once per PERIOD clk cycles. Exposes four word registers on a
// simple select/ready memory-bus slave.
//
// Build option: define LED_SCANNER_TRAIL_EN to add a dimmed (25% duty)
// trail LED behind the head in bounce and wrap modes.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   display_out     LED drive, 1 = lit (registered)
//   address_in      byte address; [3:2] selects CTRL/PERIOD/PATTERN/STATUS
//   sel_in          slave select, held by the master until ready_out
//   read_in         1 = read, 0 = write
//   read_value_out  read data, zero whenever ready_out is low
//   write_mask_in   per-byte write enables
//   write_value_in  write data
//   ready_out       one-cycle transfer-complete pulse (registered)
module led_scanner #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BASETIME   = 12000000,
    parameter int unsigned DEFAULT_MS = 300
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] display_out,
    input  logic [31:0]      address_in,
    input  logic             sel_in,
    input  logic             read_in,
    output logic [31:0]      read_value_out,
    input  logic [3:0]       write_mask_in,
    input  logic [31:0]      write_value_in,
    output logic             ready_out
);

    typedef enum logic [1:0] {
        MODE_STOP   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_WRAP   = 2'd2,
        MODE_MANUAL = 2'd3
    } mode_t;

    localparam logic [31:0]      PERIOD_RST = 32'(BASETIME / 1000 * DEFAULT_MS);
    localparam logic [WIDTH-1:0] HEAD_RST   = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef LED_SCANNER_TRAIL_EN
    localparam logic             TRAIL_BIT  = 1'b1;
`else
    localparam logic             TRAIL_BIT  = 1'b0;
`endif

    // State
    mode_t             mode_q,    mode_d;
    logic [31:0]       period_q,  period_d;
    logic [WIDTH-1:0]  pattern_q, pattern_d;
    logic [WIDTH-1:0]  head_q,    head_d;
    logic              dir_q,     dir_d;
    logic [31:0]       presc_q,   presc_d;
    logic              ready_q,   ready_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [WIDTH-1:0]  display_q, display_d;
`ifdef LED_SCANNER_TRAIL_EN
    logic [WIDTH-1:0]  prev_q,    prev_d;
    logic [1:0]        pwm_q,     pwm_d;
`endif

    // Combinational helpers
    logic              accept;
    logic              wr_en;
    logic              step;
    logic [31:0]       eff_period;
    mode_t             wr_mode;
    logic [4:0]        head_idx;
    logic [31:0]       status_w;

    // Address bits outside [3:2] are decoded by the interconnect, not here.
    logic unused_addr;
    assign unused_addr = ^{address_in[31:4], address_in[1:0]};

    // Position of the one-hot head, reported in STATUS.
    always_comb begin
        head_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (head_q[i]) begin
                head_idx = 5'(i);
            end
        end
    end

    assign status_w = {22'd0, TRAIL_BIT, dir_q, 3'd0, head_idx};

    always_comb begin
        accept     = sel_in && !ready_q;
        wr_en      = accept && !read_in;
        eff_period = (period_q == '0) ? 32'd1 : period_q;
        step       = (presc_q >= eff_period - 32'd1);
        wr_mode    = mode_t'(write_value_in[1:0]);

        presc_d    = step ? '0 : presc_q + 32'd1;
        mode_d     = mode_q;
        period_d   = period_q;
        pattern_d  = pattern_q;
        head_d     = head_q;
        dir_d      = dir_q;

        // Step first; a register write below overrides any field it touches.
        if (step) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir_q) begin
                        if (head_q[WIDTH-1]) begin
                            dir_d  = 1'b0;
                            head_d = head_q >> 1;
                        end else begin
                            head_d = head_q << 1;
                        end
                    end else begin
                        if (head_q[0]) begin
                            dir_d  = 1'b1;
                            head_d = head_q << 1;
                        end else begin
                            head_d = head_q >> 1;
                        end
                    end
                end
                MODE_WRAP: begin
                    head_d = {head_q[WIDTH-2:0], head_q[WIDTH-1]};
                    dir_d  = 1'b1;
                end
                default: ;
            endcase
        end

        if (wr_en) begin
            case (address_in[3:2])
                2'd0: begin
                    if (write_mask_in[0] && (wr_mode != mode_q)) begin
                        mode_d = wr_mode;
                        // Leaving manual restarts the sweep from bit 0.
                        if ((mode_q == MODE_MANUAL) &&
                            ((wr_mode == MODE_BOUNCE) || (wr_mode == MODE_WRAP))) begin
                            head_d  = HEAD_RST;
                            dir_d   = 1'b1;
                            presc_d = '0;
                        end
                    end
                end
                2'd1: begin
                    for (int unsigned b = 0; b < 4; b++) begin
                        if (write_mask_in[b]) begin
                            period_d[8*b +: 8] = write_value_in[8*b +: 8];
                        end
                    end
                    presc_d = '0;
                end
                2'd2: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (write_mask_in[i/8]) begin
                            pattern_d[i] = write_value_in[i];
                        end
                    end
                end
                default: ;
            endcase
        end

`ifdef LED_SCANNER_TRAIL_EN
        pwm_d  = pwm_q + 2'd1;
        prev_d = prev_q;
        if (head_d != head_q) begin
            prev_d = head_q;
        end
        if (mode_d != mode_q) begin
            prev_d = '0;
        end
`endif

        // Display follows next-state values so it tracks head without lag.
        case (mode_d)
            MODE_MANUAL: display_d = pattern_d;
            MODE_STOP:   display_d = head_d;
`ifdef LED_SCANNER_TRAIL_EN
            default:     display_d = head_d | (prev_d & {WIDTH{pwm_d == 2'd0}});
`else
            default:     display_d = head_d;
`endif
        endcase

        ready_d = accept;
        rdata_d = '0;
        if (accept && read_in) begin
            case (address_in[3:2])
                2'd0:    rdata_d = {30'd0, mode_q};
                2'd1:    rdata_d = period_q;
                2'd2:    rdata_d = 32'(head_q);
                default: rdata_d = status_w;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_BOUNCE;
            period_q  <= PERIOD_RST;
            pattern_q <= '0;
            head_q    <= HEAD_RST;
            dir_q     <= 1'b1;
            presc_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            display_q <= HEAD_RST;
`ifdef LED_SCANNER_TRAIL_EN
            prev_q    <= '0;
            pwm_q     <= '0;
`endif
        end else begin
            mode_q    <= mode_d;
            period_q  <= period_d;
            pattern_q <= pattern_d;
            head_q    <= head_d;
            dir_q     <= dir_d;
            presc_q   <= presc_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            display_q <= display_d;
`ifdef LED_SCANNER_TRAIL_EN
            prev_q    <= prev_d;
            pwm_q     <= pwm_d;
`endif
        end
    end

    assign display_out    = display_q;
    assign ready_out      = ready_q;
    assign read_value_out = rdata_q;

endmodule

// File: tb/tb_led_scanner.sv
module tb_led_scanner;

    localparam int unsigned W = 4;

`ifdef LED_SCANNER_TRAIL_EN
    localparam logic [31:0] ST_TRAIL = 32'h200;
`else
    localparam logic [31:0] ST_TRAIL = 32'h000;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  display_out;
    logic [31:0]   address_in;
    logic          sel_in;
    logic          read_in;
    logic [31:0]   read_value_out;
    logic [3:0]    write_mask_in;
    logic [31:0]   write_value_in;
    logic          ready_out;

    int total;
    int bad;

    led_scanner #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .display_out    (display_out),
        .address_in     (address_in),
        .sel_in         (sel_in),
        .read_in        (read_in),
        .read_value_out (read_value_out),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .ready_out      (ready_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One bus transfer; returns at the sample point where ready_out is high.
    task automatic bus_xfer(input logic [31:0] addr, input logic rd,
                            input logic [31:0] wdata, input logic [3:0] mask,
                            output logic [31:0] rdata);
        int n;
        address_in     = addr;
        read_in        = rd;
        write_value_in = wdata;
        write_mask_in  = mask;
        sel_in         = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready_out && n < 20);
        if (!ready_out) begin
            total++;
            bad++;
            $display("FAIL bus_timeout addr=%h got ready=%b exp=1", addr, ready_out);
        end
        rdata  = read_value_out;
        sel_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        total++; if (display_out !== 4'h1) begin bad++; $display("FAIL reset_display got=%h exp=1", display_out); end
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_out); end
        total++; if (read_value_out !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", read_value_out); end
        bus_xfer(32'h0, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL reset_ctrl got=%h exp=1", rd); end
        bus_xfer(32'hFFFF_FFF4, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'd3600000) begin bad++; $display("FAIL reset_period got=%0d exp=3600000", rd); end
        bus_xfer(32'hC, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== (32'h100 | ST_TRAIL)) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h100 | ST_TRAIL); end
    endtask

    // PERIOD=3 bounce sweep, polling STATUS with sel_in held high throughout.
    task automatic test_bounce();
        logic [31:0] rd;
        logic [3:0]  seq [8];
        logic [31:0] st  [8];
        logic [3:0]  prev, mask;
        logic        rexp;
        logic [31:0] sexp;
        int          s;
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        st  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h002, 32'h001, 32'h000, 32'h101};
        do_reset();
        bus_xfer(32'h4, 1'b0, 32'd3, 4'hF, rd);
        address_in = 32'hC;
        read_in    = 1'b1;
        sel_in     = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            s    = k / 3;
            prev = (s == 0) ? 4'h0 : seq[s-1];
            mask = 4'hF;
`ifdef LED_SCANNER_TRAIL_EN
            mask = ~prev;
`endif
            total++;
            if ((display_out & mask) !== (seq[s] & mask)) begin
                bad++; $display("FAIL bounce_display k=%0d got=%h exp=%h", k, display_out, seq[s]);
            end
            rexp = (k >= 2) && (k % 2 == 0);
            total++;
            if (ready_out !== rexp) begin
                bad++; $display("FAIL bounce_ready k=%0d got=%b exp=%b", k, ready_out, rexp);
            end
            sexp = rexp ? (st[(k-1)/3] | ST_TRAIL) : 32'h0;
            total++;
            if (read_value_out !== sexp) begin
                bad++; $display("FAIL bounce_status k=%0d got=%h exp=%h", k, read_value_out, sexp);
            end
        end
        sel_in  = 1'b0;
        read_in = 1'b0;
    endtask

    // Wrap at one step per cycle; per=0 must behave exactly like per=1.
    task automatic test_wrap(input logic [31:0] per);
        logic [31:0] rd;
        logic [3:0]  seq [4];
        logic [3:0]  mask;
        logic        rexp;
        logic [31:0] sexp;
        seq = '{4'h1, 4'h2, 4'h4, 4'h8};
        do_reset();
        bus_xfer(32'h0, 1'b0, 32'h2, 4'hF, rd);
        bus_xfer(32'h4, 1'b0, per, 4'hF, rd);
        total++;
        if (display_out !== 4'h1) begin bad++; $display("FAIL wrap%0d_start got=%h exp=1", per, display_out); end
        address_in = 32'hC;
        read_in    = 1'b1;
        sel_in     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            mask = 4'hF;
`ifdef LED_SCANNER_TRAIL_EN
            mask = ~seq[(k-1)%4];
`endif
            total++;
            if ((display_out & mask) !== (seq[k%4] & mask)) begin
                bad++; $display("FAIL wrap%0d_display k=%0d got=%h exp=%h", per, k, display_out, seq[k%4]);
            end
            rexp = (k >= 2) && (k % 2 == 0);
            sexp = rexp ? (32'h100 | 32'((k-1)%4) | ST_TRAIL) : 32'h0;
            total++;
            if (read_value_out !== sexp) begin
                bad++; $display("FAIL wrap%0d_status k=%0d got=%h exp=%h", per, k, read_value_out, sexp);
            end
        end
        sel_in  = 1'b0;
        read_in = 1'b0;
    endtask

    task automatic test_manual();
        logic [31:0] rd;
        bus_xfer(32'h8, 1'b0, 32'hA, 4'hF, rd);
        bus_xfer(32'h4, 1'b0, 32'd10, 4'hF, rd);
        bus_xfer(32'h0, 1'b0, 32'h3, 4'hF, rd);
        @(posedge clk);
        #1;
        total++; if (display_out !== 4'hA) begin bad++; $display("FAIL manual_display got=%h exp=a", display_out); end
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL manual_ready_drop got=%b exp=0", ready_out); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (display_out !== 4'hA) begin bad++; $display("FAIL manual_hold got=%h exp=a", display_out); end
        bus_xfer(32'h0, 1'b0, 32'h1, 4'hF, rd);
        total++; if (display_out !== 4'h1) begin bad++; $display("FAIL manual_exit_display got=%h exp=1", display_out); end
        bus_xfer(32'hC, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== (32'h100 | ST_TRAIL)) begin bad++; $display("FAIL manual_exit_status got=%h exp=%h", rd, 32'h100 | ST_TRAIL); end
        bus_xfer(32'h8, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL manual_head_read got=%h exp=1", rd); end
        total++; if (display_out !== 4'h1) begin bad++; $display("FAIL manual_exit_hold got=%h exp=1", display_out); end
    endtask

    task automatic test_byte_mask();
        logic [31:0] rd;
        bus_xfer(32'h4, 1'b0, 32'h0000_0005, 4'b0001, rd);
        bus_xfer(32'h4, 1'b0, 32'h0000_0100, 4'b0010, rd);
        bus_xfer(32'h4, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h105) begin bad++; $display("FAIL mask_period got=%h exp=105", rd); end
        bus_xfer(32'h0, 1'b0, 32'h3, 4'b1110, rd);
        bus_xfer(32'h0, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL mask_ctrl_lane0_off got=%h exp=1", rd); end
        bus_xfer(32'hC, 1'b0, 32'hFFFF_FFFF, 4'hF, rd);
        bus_xfer(32'h0, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL status_write_ctrl got=%h exp=1", rd); end
        bus_xfer(32'h4, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== 32'h105) begin bad++; $display("FAIL status_write_period got=%h exp=105", rd); end
    endtask

    task automatic test_hold();
        @(posedge clk);
        #1;
        address_in = 32'h4;
        read_in    = 1'b1;
        sel_in     = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL hold_ready1 got=%b exp=1", ready_out); end
        total++; if (read_value_out !== 32'h105) begin bad++; $display("FAIL hold_rdata got=%h exp=105", read_value_out); end
        @(posedge clk);
        #1;
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL hold_ready2 got=%b exp=0", ready_out); end
        total++; if (read_value_out !== 32'h0) begin bad++; $display("FAIL hold_rdata_idle got=%h exp=0", read_value_out); end
        repeat (3) @(posedge clk);
        #1;
        sel_in  = 1'b0;
        read_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [3:0]  mask;
        do_reset();
        bus_xfer(32'h4, 1'b0, 32'd1, 4'hF, rd);
        address_in = 32'hC;
        read_in    = 1'b1;
        sel_in     = 1'b1;
        @(posedge clk);
        #1;
        mask = 4'hF;
`ifdef LED_SCANNER_TRAIL_EN
        mask = 4'hE;
`endif
        total++; if ((display_out & mask) !== (4'h2 & mask)) begin bad++; $display("FAIL mid_display1 got=%h exp=2", display_out); end
        @(posedge clk);
        #1;
`ifdef LED_SCANNER_TRAIL_EN
        mask = 4'hD;
`endif
        total++; if ((display_out & mask) !== (4'h4 & mask)) begin bad++; $display("FAIL mid_display2 got=%h exp=4", display_out); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", ready_out); end
        total++; if (read_value_out !== (32'h101 | ST_TRAIL)) begin bad++; $display("FAIL mid_status got=%h exp=%h", read_value_out, 32'h101 | ST_TRAIL); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (display_out !== 4'h1) begin bad++; $display("FAIL midrst_display got=%h exp=1", display_out); end
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ready_out); end
        total++; if (read_value_out !== 32'h0) begin bad++; $display("FAIL midrst_rdata got=%h exp=0", read_value_out); end
        reset   = 1'b0;
        sel_in  = 1'b0;
        read_in = 1'b0;
        bus_xfer(32'hC, 1'b1, 32'h0, 4'h0, rd);
        total++; if (rd !== (32'h100 | ST_TRAIL)) begin bad++; $display("FAIL midrst_status got=%h exp=%h", rd, 32'h100 | ST_TRAIL); end
    endtask

`ifdef LED_SCANNER_TRAIL_EN
    // Head sits on bit 2 (arrived from bit 1) for samples 40..59.
    task automatic test_trail();
        logic [31:0] rd;
        int          cnt;
        do_reset();
        bus_xfer(32'h4, 1'b0, 32'd20, 4'hF, rd);
        cnt = 0;
        for (int k = 1; k <= 56; k++) begin
            @(posedge clk);
            #1;
            if (k >= 41) begin
                total++;
                if ((display_out & 4'b1101) !== 4'b0100) begin
                    bad++; $display("FAIL trail_head k=%0d got=%h exp=4 (+bit1)", k, display_out);
                end
                if (display_out[1]) cnt++;
            end
        end
        total++;
        if (cnt !== 4) begin bad++; $display("FAIL trail_duty got=%0d exp=4", cnt); end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        sel_in         = 1'b0;
        read_in        = 1'b0;
        address_in     = '0;
        write_mask_in  = '0;
        write_value_in = '0;
        total          = 0;
        bad            = 0;
        test_reset();
        test_bounce();
        test_wrap(32'd1);
        test_wrap(32'd0);
        test_manual();
        test_byte_mask();
        test_hold();
        test_reset_mid();
`ifdef LED_SCANNER_TRAIL_EN
        test_trail();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
